// File: rtl/scp_079_gen_if.sv
// rtl/scp_079_gen_if.sv - lamp sample and supervisor result bundle for scp_079_gen
interface scp_079_gen_if #(
  parameter int TW      = 6,
  parameter int N_STEPS = 4
);
  logic                   green;
  logic                   yellow;
  logic                   red;
  logic [2*N_STEPS-1:0]   pat;
  logic [TW-1:0]          ph_count;
  logic [2:0]             state;
  logic                   a1;
  logic                   a2;
  logic                   a3;
  logic                   cheat_out;

  // lamp/pattern source side
  modport master (
    output green, yellow, red, pat,
    input  ph_count, state, a1, a2, a3, cheat_out
  );

  // supervisor side
  modport slave (
    input  green, yellow, red, pat,
    output ph_count, state, a1, a2, a3, cheat_out
  );
endinterface

// File: rtl/scp_079_gen.sv
// rtl/scp_079_gen.sv - light-phase supervisor: phase timing, overrun alerts, fault and cheat-blink detection (option: SCP079_ALERT_LATCH_EN)
module scp_079_gen #(
  parameter int TW         = 6,
  parameter int N_STEPS    = 4,
  parameter int GREEN_MAX  = 35,
  parameter int YELLOW_MAX = 5,
  parameter int RED_MAX    = 25,
  parameter int SHORT_MAX  = 3,
  parameter int CHEAT_HOLD = 8
) (
  input logic          clock,
  input logic          reset,
  scp_079_gen_if.slave bus
);
  localparam int IW = (N_STEPS > 1) ? $clog2(N_STEPS) : 1;
  localparam int HW = (CHEAT_HOLD > 0) ? $clog2(CHEAT_HOLD + 1) : 1;

  localparam logic [TW-1:0] CNT_MAX   = '1;
  localparam logic [TW-1:0] G_LIM     = TW'(GREEN_MAX);
  localparam logic [TW-1:0] Y_LIM     = TW'(YELLOW_MAX);
  localparam logic [TW-1:0] R_LIM     = TW'(RED_MAX);
  localparam logic [TW-1:0] S_LIM     = TW'(SHORT_MAX);
  localparam logic [IW-1:0] LAST_IDX  = IW'(N_STEPS - 1);
  localparam logic [HW-1:0] HOLD_LOAD = HW'(CHEAT_HOLD);

  // colour codes share their low two bits with the pattern step encoding
  typedef enum logic [2:0] {
    C_OFF = 3'd0,
    C_G   = 3'd1,
    C_Y   = 3'd2,
    C_R   = 3'd3,
    C_ILL = 3'd4
  } code_t;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_GREEN  = 3'd1,
    S_YELLOW = 3'd2,
    S_RED    = 3'd3,
    S_FAULT  = 3'd4,
    S_CHEAT  = 3'd5
  } state_t;

  code_t         code;
  code_t         prev_code;
  state_t        state;
  logic [TW-1:0] ph_count;
  logic [IW-1:0] idx;
  logic [HW-1:0] hold;
  logic [1:0]    cur_step;
  logic          a1, a2, a3, cheat_out;

  logic changed, phase_end, is_short, is_ill;
  logic step_hit, first_hit, complete, hold_active;
  logic g_over, y_over, r_over;

  // decode the sampled lamp drives into one colour code
  always_comb begin
    code = C_OFF;
    case ({bus.green, bus.yellow, bus.red})
      3'b000:  code = C_OFF;
      3'b100:  code = C_G;
      3'b010:  code = C_Y;
      3'b001:  code = C_R;
      default: code = C_ILL;
    endcase
  end

  // select the pattern step the matcher is currently waiting for
  always_comb begin
    cur_step = 2'b00;
    for (int i = 0; i < N_STEPS; i++) begin
      if (idx == IW'(i)) cur_step = bus.pat[2*i +: 2];
    end
  end

  // a phase ends only when a real colour gives way to something else
  assign changed     = (code != prev_code);
  assign phase_end   = changed && (prev_code == C_G || prev_code == C_Y || prev_code == C_R);
  assign is_short    = (ph_count <= S_LIM);
  assign is_ill      = (code == C_ILL);
  assign step_hit    = phase_end && is_short && (prev_code[1:0] == cur_step);
  assign first_hit   = phase_end && is_short && (prev_code[1:0] == bus.pat[1:0]);
  // an illegal lamp combination on the same edge vetoes the match
  assign complete    = step_hit && (idx == LAST_IDX) && !is_ill;
  assign hold_active = complete || (hold != '0);

  // overrun uses the pre-edge count, so the alert appears on phase cycle LIMIT+1
  assign g_over = (code == C_G) && !changed && (ph_count >= G_LIM);
  assign y_over = (code == C_Y) && !changed && (ph_count >= Y_LIM);
  assign r_over = (code == C_R) && !changed && (ph_count >= R_LIM);

  // supervisor state: phase counter, matcher, hold timer, alerts and reported state
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      prev_code <= C_OFF;
      ph_count  <= '0;
      idx       <= '0;
      hold      <= '0;
      cheat_out <= 1'b0;
      a1        <= 1'b0;
      a2        <= 1'b0;
      a3        <= 1'b0;
      state     <= S_IDLE;
    end else begin
      prev_code <= code;

      if (changed)                 ph_count <= TW'(1);
      else if (ph_count != CNT_MAX) ph_count <= ph_count + 1'b1;

      if (is_ill)         idx <= '0;
      else if (step_hit)  idx <= (idx == LAST_IDX) ? '0 : idx + 1'b1;
      else if (phase_end) idx <= first_hit ? IW'(1) : '0;

      if (complete)          hold <= HOLD_LOAD;
      else if (hold != '0)   hold <= hold - 1'b1;
      cheat_out <= hold_active;

`ifdef SCP079_ALERT_LATCH_EN
      if (state == S_FAULT && code == C_OFF) begin
        a1 <= 1'b0;
        a2 <= 1'b0;
        a3 <= 1'b0;
      end else begin
        a1 <= a1 | g_over;
        a2 <= a2 | r_over;
        a3 <= a3 | y_over;
      end
`else
      a1 <= g_over;
      a2 <= r_over;
      a3 <= y_over;
`endif

      if (is_ill)                 state <= S_FAULT;
      else if (state == S_FAULT)  state <= (code == C_OFF) ? S_IDLE : S_FAULT;
      else if (hold_active)       state <= S_CHEAT;
      else begin
        case (code)
          C_G:     state <= S_GREEN;
          C_Y:     state <= S_YELLOW;
          C_R:     state <= S_RED;
          default: state <= S_IDLE;
        endcase
      end
    end
  end

  assign bus.ph_count  = ph_count;
  assign bus.state     = state;
  assign bus.a1        = a1;
  assign bus.a2        = a2;
  assign bus.a3        = a3;
  assign bus.cheat_out = cheat_out;
endmodule

// File: tb/tb_scp_079_gen.sv
// tb/tb_scp_079_gen.sv - directed self-checking bench for scp_079_gen
module tb_scp_079_gen;
  logic clock = 1'b0;
  logic reset = 1'b1;
  int   total = 0;
  int   bad   = 0;

`ifdef SCP079_ALERT_LATCH_EN
  localparam logic LATCH = 1'b1;
`else
  localparam logic LATCH = 1'b0;
`endif

  scp_079_gen_if #(.TW(6), .N_STEPS(4)) bus ();

  scp_079_gen dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // drive lamps for one clock, sample 1 time unit after the edge
  task automatic lamps(input logic g, input logic y, input logic r);
    bus.green  = g;
    bus.yellow = y;
    bus.red    = r;
    @(posedge clock);
    #1;
  endtask

  task automatic run(input logic g, input logic y, input logic r, input int n);
    for (int k = 0; k < n; k++) lamps(g, y, r);
  endtask

  // blink sequence G, R, G, Y with the given lengths
  task automatic seq(input int g1, input int r1, input int g2, input int y1);
    run(1'b1, 1'b0, 1'b0, g1);
    run(1'b0, 1'b0, 1'b1, r1);
    run(1'b1, 1'b0, 1'b0, g2);
    run(1'b0, 1'b1, 1'b0, y1);
  endtask

  initial begin
    bus.green  = 1'b0;
    bus.yellow = 1'b0;
    bus.red    = 1'b0;
    bus.pat    = 8'b10_01_11_01;
    reset      = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    chk("rst_state", bus.state, 0);
    chk("rst_ph", bus.ph_count, 0);
    chk("rst_a1", bus.a1, 0);
    chk("rst_a2", bus.a2, 0);
    chk("rst_a3", bus.a3, 0);
    chk("rst_cheat", bus.cheat_out, 0);
    reset = 1'b0;
    lamps(1'b0, 1'b0, 1'b0);
    chk("off_state", bus.state, 0);

    // green held 40 cycles: a1 from cycle 36
    for (int i = 1; i <= 40; i++) begin
      lamps(1'b1, 1'b0, 1'b0);
      chk("g_ph", bus.ph_count, i);
      chk("g_a1", bus.a1, (i >= 36) ? 1 : 0);
      chk("g_state", bus.state, 1);
    end
    lamps(1'b0, 1'b1, 1'b0);
    chk("gy_ph", bus.ph_count, 1);
    chk("gy_a1", bus.a1, LATCH);
    chk("gy_state", bus.state, 2);

    // red exactly 25 cycles: no a2
    for (int i = 1; i <= 25; i++) begin
      lamps(1'b0, 1'b0, 1'b1);
      chk("r_a2", bus.a2, 0);
    end
    chk("r_ph25", bus.ph_count, 25);
    lamps(1'b0, 1'b1, 1'b0);
    chk("ry_ph", bus.ph_count, 1);
    chk("ry_a2", bus.a2, 0);
    // yellow continues to 7 cycles: a3 from cycle 6
    for (int i = 2; i <= 7; i++) begin
      lamps(1'b0, 1'b1, 1'b0);
      chk("y_ph", bus.ph_count, i);
      chk("y_a3", bus.a3, (i >= 6) ? 1 : 0);
    end
    lamps(1'b0, 1'b0, 1'b0);
    chk("yo_a3", bus.a3, LATCH);
    chk("yo_state", bus.state, 0);
    lamps(1'b0, 1'b0, 1'b0);

    // valid cheat G2 R1 G3 Y2, then red
    seq(2, 1, 3, 2);
    chk("ch_pre", bus.cheat_out, 0);
    for (int j = 1; j <= 12; j++) begin
      lamps(1'b0, 1'b0, 1'b1);
      chk("ch_out", bus.cheat_out, (j <= 9) ? 1 : 0);
      chk("ch_state", bus.state, (j <= 9) ? 5 : 3);
    end

    // third blink too long: no cheat
    run(1'b0, 1'b0, 1'b0, 2);
    seq(2, 1, 4, 2);
    lamps(1'b0, 1'b0, 1'b1);
    chk("long_cheat", bus.cheat_out, 0);
    chk("long_state", bus.state, 3);
    run(1'b0, 1'b0, 1'b1, 2);
    chk("long_cheat2", bus.cheat_out, 0);

    // mismatching short G restarts at step 1; OFF phase is transparent
    run(1'b1, 1'b0, 1'b0, 2);
    lamps(1'b0, 1'b0, 1'b0);
    seq(2, 1, 3, 2);
    lamps(1'b0, 1'b0, 1'b1);
    chk("rs_cheat", bus.cheat_out, 1);
    chk("rs_state", bus.state, 5);
    run(1'b0, 1'b0, 1'b1, 10);
    chk("rs_end", bus.cheat_out, 0);
    chk("rs_end_st", bus.state, 3);

    // ILL on the completion edge vetoes the cheat, fault holds until OFF
    seq(2, 1, 3, 2);
    lamps(1'b1, 1'b0, 1'b1);
    chk("ill_state", bus.state, 4);
    chk("ill_cheat", bus.cheat_out, 0);
    for (int i = 0; i < 3; i++) begin
      lamps(1'b1, 1'b0, 1'b0);
      chk("flt_hold", bus.state, 4);
    end
    lamps(1'b0, 1'b0, 1'b0);
    chk("flt_exit", bus.state, 0);
    chk("flt_a1", bus.a1, 0);
    chk("flt_a3", bus.a3, 0);

    // ILL after OFF discards a partial match at the last step
    run(1'b1, 1'b0, 1'b0, 2);
    run(1'b0, 1'b0, 1'b1, 1);
    run(1'b1, 1'b0, 1'b0, 3);
    lamps(1'b0, 1'b0, 1'b0);
    lamps(1'b1, 1'b0, 1'b1);
    chk("ill2_state", bus.state, 4);
    lamps(1'b0, 1'b0, 1'b0);
    chk("ill2_exit", bus.state, 0);
    run(1'b0, 1'b1, 1'b0, 2);
    lamps(1'b0, 1'b0, 1'b1);
    chk("disc_cheat", bus.cheat_out, 0);
    chk("disc_state", bus.state, 3);

    // asynchronous reset during a cheat hold
    seq(2, 1, 3, 2);
    lamps(1'b0, 1'b0, 1'b1);
    chk("ar_cheat_on", bus.cheat_out, 1);
    lamps(1'b0, 1'b0, 1'b1);
    #3 reset = 1'b1;
    #1;
    chk("ar_cheat", bus.cheat_out, 0);
    chk("ar_state", bus.state, 0);
    chk("ar_ph", bus.ph_count, 0);
    #2 reset = 1'b0;
    @(posedge clock);
    #1;
    chk("ar_post_cheat", bus.cheat_out, 0);
    chk("ar_post_state", bus.state, 3);

    // asynchronous reset during a green overrun
    run(1'b1, 1'b0, 1'b0, 37);
    chk("ag_a1_on", bus.a1, 1);
    #3 reset = 1'b1;
    #1;
    chk("ag_a1", bus.a1, 0);
    chk("ag_ph", bus.ph_count, 0);
    chk("ag_state", bus.state, 0);
    #2 reset = 1'b0;
    lamps(1'b1, 1'b0, 1'b0);
    chk("ag_post_ph", bus.ph_count, 1);
    chk("ag_post_a1", bus.a1, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
